// File: rtl/struct_field_serializer.sv
// struct_field_serializer
//   Accepts one packed struct (NUM_FIELDS fields of FIELD_W bits) on a
//   valid/ready input and emits it one field per beat, first-declared field
//   (the MSB slice) first.
//
//   A new struct can be accepted in the same cycle that the last field of
//   the previous struct handshakes. This gives back-to-back operation with
//   no bubble. A running count of fully emitted structs is kept. The count
//   wraps silently.
//
// Ports
//   clk, rst_n    clock; asynchronous active-low reset
//   in_valid      in_struct is valid
//   in_ready      serializer can accept in_struct this cycle
//   in_struct     packed struct; field 0 occupies [W*N-1 -: W]
//   out_valid     out_data is valid
//   out_ready     downstream accepts the beat
//   out_data      current field value
//   out_idx       index of the current field
//   out_last      current beat carries field NUM_FIELDS-1
//   struct_count  number of structs whose last field handshook
module struct_field_serializer #(
  parameter int FIELD_W    = 32,
  parameter int NUM_FIELDS = 2,
  parameter int COUNT_W    = 16,
  localparam int IDX_W     = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1,
  localparam int STRUCT_W  = FIELD_W * NUM_FIELDS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [STRUCT_W-1:0] in_struct,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [FIELD_W-1:0]  out_data,
  output logic [IDX_W-1:0]    out_idx,
  output logic                out_last,
  output logic [COUNT_W-1:0]  struct_count
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FIELDS - 1);
  localparam logic             ONE_FLD  = (NUM_FIELDS == 1);

  state_t              state;
  // Held struct, shifted left by one field per beat. The field on the wire
  // is therefore always the top slice. Emptied lanes fill with zeros.
  logic [STRUCT_W-1:0] held;
  logic                fire_out;
  logic                accept;

  assign out_data = held[STRUCT_W-1 -: FIELD_W];
  assign fire_out = out_valid & out_ready;
  // in_ready depends only on state and out_ready. There is no path from in_valid.
  assign in_ready = (state == IDLE) | (fire_out & out_last);
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      held         <= '0;
      out_valid    <= 1'b0;
      out_idx      <= '0;
      out_last     <= 1'b0;
      struct_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            held      <= in_struct;
            out_idx   <= '0;
            out_last  <= ONE_FLD;
            out_valid <= 1'b1;
            state     <= SEND;
          end
        end
        SEND: begin
          if (fire_out) begin
            if (!out_last) begin
              held     <= held << FIELD_W;
              out_idx  <= out_idx + IDX_W'(1);
              out_last <= ((out_idx + IDX_W'(1)) == LAST_IDX);
            end else begin
              struct_count <= struct_count + COUNT_W'(1);
              if (accept) begin
                // Reload on the last beat keeps the stream gap-free.
                held     <= in_struct;
                out_idx  <= '0;
                out_last <= ONE_FLD;
              end else begin
                held      <= '0;
                out_idx   <= '0;
                out_last  <= 1'b0;
                out_valid <= 1'b0;
                state     <= IDLE;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_struct_field_serializer.sv
module tb_struct_field_serializer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // dut0: default {int a; int b;}
  logic        iv0, ir0, ov0, or0, ol0;
  logic [63:0] is0;
  logic [31:0] od0;
  logic [0:0]  oi0;
  logic [15:0] sc0;

  // dut1: 2-bit counter for the wrap check
  logic        iv1, ir1, ov1, or1, ol1;
  logic [63:0] is1;
  logic [31:0] od1;
  logic [0:0]  oi1;
  logic [1:0]  sc1;

  // dut2: single-field struct
  logic        iv2, ir2, ov2, or2, ol2;
  logic [31:0] is2;
  logic [31:0] od2;
  logic [0:0]  oi2;
  logic [15:0] sc2;

  struct_field_serializer #(.FIELD_W(32), .NUM_FIELDS(2), .COUNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .in_struct(is0),
    .out_valid(ov0), .out_ready(or0), .out_data(od0), .out_idx(oi0),
    .out_last(ol0), .struct_count(sc0));

  struct_field_serializer #(.FIELD_W(32), .NUM_FIELDS(2), .COUNT_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .in_struct(is1),
    .out_valid(ov1), .out_ready(or1), .out_data(od1), .out_idx(oi1),
    .out_last(ol1), .struct_count(sc1));

  struct_field_serializer #(.FIELD_W(32), .NUM_FIELDS(1), .COUNT_W(16)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .in_struct(is2),
    .out_valid(ov2), .out_ready(or2), .out_data(od2), .out_idx(oi2),
    .out_last(ol2), .struct_count(sc2));

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [63:0] s;
    int          stall;
    logic [31:0] e0;
    logic [31:0] e1;
  } vec_t;

  // One struct through dut0 with `stall` cycles of backpressure on beat 0.
  task automatic send_one(input vec_t v, input logic [15:0] cnt_before);
    @(negedge clk);
    iv0 = 1'b1; is0 = v.s; or0 = 1'b1;
    #1 check("idle_in_ready", ir0, 1);
    @(negedge clk);
    iv0 = 1'b0; is0 = 64'hBAD0_BAD0_BAD0_BAD0;  // ignored while busy
    for (int i = 0; i < v.stall; i++) begin
      or0 = 1'b0;
      #1;
      check("stall_valid", ov0, 1);
      check("stall_data", od0, v.e0);
      check("stall_idx", oi0, 0);
      check("stall_in_ready", ir0, 0);
      @(negedge clk);
    end
    or0 = 1'b1;
    #1;
    check("beat0_valid", ov0, 1);
    check("beat0_data", od0, v.e0);
    check("beat0_idx", oi0, 0);
    check("beat0_last", ol0, 0);
    check("beat0_in_ready", ir0, 0);
    @(negedge clk);
    #1;
    check("beat1_valid", ov0, 1);
    check("beat1_data", od0, v.e1);
    check("beat1_idx", oi0, 1);
    check("beat1_last", ol0, 1);
    check("beat1_in_ready", ir0, 1);
    check("count_before_last", sc0, cnt_before);
    @(negedge clk);
    #1;
    check("after_valid", ov0, 0);
    check("after_last", ol0, 0);
    check("after_count", sc0, cnt_before + 16'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[4];
    logic [63:0] bb[3];
    logic [31:0] bexp[6];
    logic [1:0]  wrap_exp[5];
    logic [31:0] d2[4];
    logic [15:0] cnt;

    vecs[0] = '{s: 64'h0000_0000_0000_0001, stall: 0, e0: 32'h0000_0000, e1: 32'h0000_0001};
    vecs[1] = '{s: 64'hDEAD_BEEF_CAFE_F00D, stall: 3, e0: 32'hDEAD_BEEF, e1: 32'hCAFE_F00D};
    vecs[2] = '{s: 64'hFFFF_FFFF_8000_0000, stall: 1, e0: 32'hFFFF_FFFF, e1: 32'h8000_0000};
    vecs[3] = '{s: 64'hA5A5_A5A5_5A5A_5A5A, stall: 0, e0: 32'hA5A5_A5A5, e1: 32'h5A5A_5A5A};

    iv0 = 0; or0 = 0; is0 = '0;
    iv1 = 0; or1 = 0; is1 = '0;
    iv2 = 0; or2 = 0; is2 = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_valid", ov0, 0);
    check("rst_data", od0, 0);
    check("rst_idx", oi0, 0);
    check("rst_last", ol0, 0);
    check("rst_count", sc0, 0);
    rst_n = 1'b1;
    #1 check("rst_in_ready", ir0, 1);

    // Table-driven single structs, with and without backpressure
    cnt = 16'd0;
    for (int i = 0; i < 4; i++) begin
      send_one(vecs[i], cnt);
      cnt = cnt + 16'd1;
    end

    // Back-to-back: three structs with no bubble
    bb[0] = 64'h0102_0304_0506_0708;
    bb[1] = 64'h1111_0000_2222_0000;
    bb[2] = 64'hFEDC_BA98_7654_3210;
    bexp = '{32'h0102_0304, 32'h0506_0708, 32'h1111_0000,
             32'h2222_0000, 32'hFEDC_BA98, 32'h7654_3210};
    @(negedge clk);
    iv0 = 1'b1; is0 = bb[0]; or0 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k / 2 + 1 < 3) is0 = bb[k / 2 + 1];
      else iv0 = 1'b0;
      #1;
      check("b2b_valid", ov0, 1);
      check("b2b_data", od0, bexp[k]);
      check("b2b_in_ready", ir0, (k % 2) == 1);
    end
    @(negedge clk);
    #1;
    check("b2b_idle", ov0, 0);
    check("b2b_count", sc0, cnt + 16'd3);

    // Counter wrap with COUNT_W=2
    wrap_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      iv1 = 1'b1; is1 = {32'(i), 32'(i + 100)}; or1 = 1'b1;
      @(negedge clk);
      iv1 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1 check("wrap_count", sc1, wrap_exp[i]);
    end

    // Single-field: one beat per struct, continuous throughput
    d2 = '{32'h1234_5678, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8765_4321};
    @(negedge clk);
    iv2 = 1'b1; is2 = d2[0]; or2 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k < 3) is2 = d2[k + 1];
      else iv2 = 1'b0;
      #1;
      check("nf1_valid", ov2, 1);
      check("nf1_data", od2, d2[k]);
      check("nf1_idx", oi2, 0);
      check("nf1_last", ol2, 1);
      check("nf1_in_ready", ir2, 1);
    end
    @(negedge clk);
    #1;
    check("nf1_idle", ov2, 0);
    check("nf1_count", sc2, 4);

    // Reset in the middle of a struct
    @(negedge clk);
    iv0 = 1'b1; is0 = 64'h1111_1111_2222_2222; or0 = 1'b1;
    @(negedge clk);
    iv0 = 1'b0;
    #1 check("mid_beat0", od0, 32'h1111_1111);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", ov0, 0);
    check("mid_rst_data", od0, 0);
    check("mid_rst_last", ol0, 0);
    check("mid_rst_count", sc0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("mid_rel_in_ready", ir0, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      check("mid_no_resume", ov0, 0);
      check("mid_no_data", od0, 0);
    end
    check("mid_count", sc0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
